// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the loader's byte-stream input and its instruction-memory
// write port.
//   in_valid / in_data / in_ready : byte stream, accepted when in_valid & in_ready
//   imem_we / imem_addr / imem_wdata : instruction-memory write port
// Modports:
//   master : stream source and memory sink (the environment around the loader)
//   slave  : the loader itself
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Accepts a frame {N[7:0], N[15:8], 4*N little-endian data bytes, checksum} and writes
// each assembled word to the instruction memory. The core is held in reset until the
// whole image is written and the checksum (sum of data bytes mod 256) matches.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   io_bus       : stream input and memory write port (slave modport)
//   o_core_rst_n : core reset, active-low; high only once the load succeeded
//   o_busy       : load in progress (after the first header byte)
//   o_done       : load succeeded
//   o_err        : bad word count or checksum; sticky until reset
module imem_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  imem_loader_if.slave   io_bus,
  output logic           o_core_rst_n,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  localparam int unsigned MaxWords = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StData,
    StCsum,
    StRun,
    StErr
  } state_e;

  state_e            r_state;
  state_e            w_state_next;

  logic [7:0]        r_n_lo;
  // One bit wider than the address so that N = MaxWords is representable.
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_idx;
  logic [1:0]        r_lane;
  logic [7:0]        r_sum;
  logic [23:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_n;
  logic              w_n_bad;
  logic [ADDR_W:0]   w_idx_inc;
  logic              w_last_word;

  always_comb begin
    w_ready = 1'b0;
    if (!i_rst) begin
      w_ready = (r_state == StHdr0) || (r_state == StHdr1) ||
                (r_state == StData) || (r_state == StCsum);
    end
  end

  assign w_accept    = io_bus.in_valid && w_ready;
  assign w_n         = {io_bus.in_data, r_n_lo};
  assign w_n_bad     = (w_n == 16'd0) || (w_n > 16'(MaxWords));
  assign w_idx_inc   = r_idx + (ADDR_W + 1)'(1);
  assign w_last_word = (w_idx_inc == r_count);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StHdr0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StHdr0: if (w_accept) w_state_next = StHdr1;
      StHdr1: if (w_accept) w_state_next = w_n_bad ? StErr : StData;
      StData: if (w_accept && (r_lane == 2'd3) && w_last_word) w_state_next = StCsum;
      StCsum: begin
        if (w_accept) w_state_next = (io_bus.in_data == r_sum) ? StRun : StErr;
      end
      StRun:   w_state_next = StRun;
      StErr:   w_state_next = StErr;
      default: w_state_next = StHdr0;
    endcase
  end

  // Datapath: header capture, lane assembly, checksum and memory write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n_lo  <= 8'd0;
      r_count <= '0;
      r_idx   <= '0;
      r_lane  <= 2'd0;
      r_sum   <= 8'd0;
      r_word  <= 24'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          StHdr0: r_n_lo <= io_bus.in_data;
          StHdr1: begin
            r_count <= w_n[ADDR_W:0];
            r_idx   <= '0;
            r_lane  <= 2'd0;
            r_sum   <= 8'd0;
          end
          StData: begin
            r_sum  <= r_sum + io_bus.in_data;
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_word[7:0]   <= io_bus.in_data;
              2'd1: r_word[15:8]  <= io_bus.in_data;
              2'd2: r_word[23:16] <= io_bus.in_data;
              default: begin
                r_wdata <= {io_bus.in_data, r_word};
                r_addr  <= r_idx[ADDR_W-1:0];
                r_we    <= 1'b1;
                r_idx   <= w_idx_inc;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.in_ready   = w_ready;
  assign io_bus.imem_we    = r_we;
  assign io_bus.imem_addr  = r_addr;
  assign io_bus.imem_wdata = r_wdata;

  assign o_core_rst_n = (r_state == StRun);
  assign o_done       = (r_state == StRun);
  assign o_err        = (r_state == StErr);
  assign o_busy       = (r_state == StHdr1) || (r_state == StData) || (r_state == StCsum);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the single-cycle RISC-V core wrapper. It accepts a framed byte stream carrying a word count, instruction words and a checksum, and writes each assembled word into the instruction-memory write port. It holds the core in reset until the load completes and the checksum matches, then releases it. This replaces bench-only preloading of the instruction memory image and sequences core start-up in hardware.

## Interface
- ADDR_W, 6, instruction-memory word-address width; MAX_WORDS = 2**ADDR_W.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; forced to 0 while rst=1.
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr  out  ADDR_W  word address, which is the word index.
- imem_wdata  out  32  assembled instruction word.
- core_rst_n  out  1  core reset, active-low; 1 only in state RUN.
- busy  out  1  state is HDR1, DATA or CSUM.
- done  out  1  state is RUN.
- err  out  1  state is ERR; sticky until rst.

## Operation
- A byte is accepted on a rising edge where in_valid=1 and in_ready=1. No other cycle has any effect.
- Frame layout:
  - 2-byte word count N, little-endian (low byte first).
  - 4·N data bytes, each word little-endian.
  - 1 checksum byte.
- Checksum = sum of all data bytes mod 256. Header bytes are excluded.
- States:
  - HDR0: accept the N low byte, go to HDR1.
  - HDR1: accept the N high byte.
    - If N=0 or N>MAX_WORDS, go to ERR.
    - Otherwise go to DATA with word index 0, byte lane 0 and sum 0.
  - DATA: each accepted byte goes to lane 0..3 (lane 0 → bits 7:0) and is added to the 8-bit sum.
    - On lane 3, the full word is registered to imem_wdata, imem_addr = word index, and imem_we pulses.
    - Word index increments after the write.
    - After word N-1 is written, go to CSUM.
  - CSUM: accept one byte. If it equals the sum, go to RUN; otherwise go to ERR.
  - RUN: in_ready=0 and core_rst_n=1. Hold until rst.
  - ERR: in_ready=0 and core_rst_n=0. Hold until rst.
- in_ready=1 in HDR0, HDR1, DATA and CSUM (when rst=0).
- Word index is ADDR_W+1 bits wide internally, so N=MAX_WORDS is legal and does not wrap.
- The sum wraps modulo 256; carries are discarded.
- Reset mid-load: the next state is HDR0 and index, lane and sum clear. Words already written stay in memory (no scrub). core_rst_n=0 on the cycle after the reset edge.
- in_valid deassertion mid-word pauses assembly; the partial lane contents are held.

## Timing
- Values after the reset edge:
  - state HDR0, so in_ready=1 once rst falls;
  - imem_we=0, imem_addr=0, imem_wdata=0;
  - core_rst_n=0, busy=0, done=0, err=0.
- Write latency: imem_we=1 for exactly the one cycle after the edge that accepts lane 3. imem_addr and imem_wdata are valid in that same cycle and hold until the next write.
- Back-to-back bytes give a maximum of one write per 4 cycles. Minimum frame time is 4N+3 accepted-byte cycles.
- The final data write and the CSUM state are the same cycle, so the checksum byte may be accepted in the cycle where imem_we=1.
- core_rst_n rises on the edge that accepts a matching checksum byte. The core's first fetch is the following edge, after the last memory write has already completed.
- err and done are mutually exclusive and rise on the same edge as the state transition.

## Test plan
- Nominal load:
  - stimulus: bytes 02 00, 93 02 50 00, 33 83 62 00, FD, with in_valid held high;
  - required: imem_we at addr 0 with 0x00500293, then addr 1 with 0x00628333;
  - then: done=1 and core_rst_n=1 one cycle after FD; in_ready=0 afterwards.
- Checksum mismatch: the same frame with last byte FC → both words written, err=1, core_rst_n stays 0, in_ready=0.
- Header limits (ADDR_W=6):
  - N=0 (00 00) → err=1 after the second byte, no imem_we;
  - N=65 (41 00) → err=1;
  - N=64 followed by 256 data bytes and a correct checksum → done=1, last write at addr 63.
- Backpressure gaps: the nominal frame with in_valid low for 1-3 cycles between random bytes → the same writes and the same words, done=1; no write while in_valid=0.
- Reset mid-load:
  - stimulus: assert rst for one cycle after 6 data bytes, then send a fresh nominal frame;
  - required: no stale lane data, first write is addr 0 with 0x00500293, done=1.
- Reset from RUN/ERR: pulse rst → core_rst_n=0, err=0, done=0 and in_ready=1 on the cycle after rst falls.
